// File: rtl/reset_sequencer.sv
// reset_sequencer: filters clock lock, then releases NUM_STAGES active-low resets in order.
// Lock loss or software reset re-asserts every stage at once and restarts the sequence.
module reset_sequencer #(
    parameter int NUM_STAGES   = 4,
    parameter int DELAY_CYCLES = 16,
    parameter int LOCK_FILTER  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_lock,
    input  logic                  i_sw_rst,
    output logic [NUM_STAGES-1:0] o_rst_n,
    output logic                  o_done
);
    localparam int LW = $clog2(LOCK_FILTER + 1);
    localparam int DW = $clog2(DELAY_CYCLES + 1);
    localparam int SW = $clog2(NUM_STAGES + 1);

    typedef enum logic [1:0] {FILTER, RELEASE, DONE} state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         lock_cnt, lock_d;
    logic [DW-1:0]         dly_cnt, dly_d;
    logic [SW-1:0]         stage_idx, idx_d;
    logic [NUM_STAGES-1:0] rst_q, rst_d;
    logic                  done_q, done_d;
    logic                  abort;

    assign abort   = !i_lock || i_sw_rst;
    assign o_rst_n = rst_q;
    assign o_done  = done_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= FILTER;
            lock_cnt  <= '0;
            dly_cnt   <= '0;
            stage_idx <= '0;
            rst_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_cnt  <= lock_d;
            dly_cnt   <= dly_d;
            stage_idx <= idx_d;
            rst_q     <= rst_d;
            done_q    <= done_d;
        end
    end

    // Stages release by shifting a 1 in from bit 0, keeping o_rst_n thermometer-coded.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_cnt;
        dly_d   = dly_cnt;
        idx_d   = stage_idx;
        rst_d   = rst_q;
        done_d  = done_q;
        case (state_q)
            FILTER: begin
                if (abort) begin
                    lock_d = '0;
                end else if (lock_cnt == LW'(LOCK_FILTER - 1)) begin
                    lock_d  = '0;
                    dly_d   = '0;
                    idx_d   = SW'(1);
                    rst_d   = NUM_STAGES'(1);
                    done_d  = (NUM_STAGES == 1);
                    state_d = (NUM_STAGES == 1) ? DONE : RELEASE;
                end else begin
                    lock_d = lock_cnt + LW'(1);
                end
            end
            RELEASE: begin
                if (dly_cnt == DW'(DELAY_CYCLES - 1)) begin
                    dly_d = '0;
                    idx_d = stage_idx + SW'(1);
                    rst_d = NUM_STAGES'({rst_q, 1'b1});
                    if (stage_idx == SW'(NUM_STAGES - 1)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    dly_d = dly_cnt + DW'(1);
                end
            end
            DONE: ;
            default: state_d = FILTER;
        endcase
        // Abort outranks any release scheduled on the same edge.
        if (abort && state_q != FILTER) begin
            state_d = FILTER;
            lock_d  = '0;
            dly_d   = '0;
            idx_d   = '0;
            rst_d   = '0;
            done_d  = 1'b0;
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of default and minimal reset_sequencer configurations.
module tb_reset_sequencer;
    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_lock = 1'b0;
    logic       i_sw_rst = 1'b0;
    logic [3:0] o_rst_n;
    logic       o_done;
    logic [0:0] m_rst_n;
    logic       m_done;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    reset_sequencer dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_lock(i_lock), .i_sw_rst(i_sw_rst),
        .o_rst_n(o_rst_n), .o_done(o_done)
    );

    reset_sequencer #(.NUM_STAGES(1), .DELAY_CYCLES(1), .LOCK_FILTER(1)) dut_min (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_lock(i_lock), .i_sw_rst(i_sw_rst),
        .o_rst_n(m_rst_n), .o_done(m_done)
    );

    typedef struct {
        int         drop_edge;
        int         sw_lo;
        int         sw_hi;
        int         chk_edge;
        logic [3:0] exp_rst;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        i_rst_n = 1'b0;
        @(negedge clk);
        for (int e = 1; e <= v.chk_edge; e++) begin
            i_lock   = (e != v.drop_edge);
            i_sw_rst = (e >= v.sw_lo && e <= v.sw_hi);
            i_rst_n  = 1'b1;
            @(negedge clk);
        end
        check($sformatf("drop%0d_sw%0d-%0d_edge%0d", v.drop_edge, v.sw_lo, v.sw_hi, v.chk_edge),
              {o_rst_n, o_done}, {v.exp_rst, v.exp_done});
    endtask

    function automatic vec_t mk(int d, int lo, int hi, int c, logic [3:0] r, logic dn);
        vec_t v;
        v.drop_edge = d; v.sw_lo = lo; v.sw_hi = hi; v.chk_edge = c;
        v.exp_rst = r; v.exp_done = dn;
        return v;
    endfunction

    initial begin
        // steady lock
        vecs.push_back(mk(0, 0, -1,  7, 4'b0000, 0));
        vecs.push_back(mk(0, 0, -1,  8, 4'b0001, 0));
        vecs.push_back(mk(0, 0, -1, 23, 4'b0001, 0));
        vecs.push_back(mk(0, 0, -1, 24, 4'b0011, 0));
        vecs.push_back(mk(0, 0, -1, 40, 4'b0111, 0));
        vecs.push_back(mk(0, 0, -1, 55, 4'b0111, 0));
        vecs.push_back(mk(0, 0, -1, 56, 4'b1111, 1));
        vecs.push_back(mk(0, 0, -1, 80, 4'b1111, 1));
        // one-cycle lock glitch in FILTER
        vecs.push_back(mk(5, 0, -1, 12, 4'b0000, 0));
        vecs.push_back(mk(5, 0, -1, 13, 4'b0001, 0));
        vecs.push_back(mk(5, 0, -1, 29, 4'b0011, 0));
        vecs.push_back(mk(5, 0, -1, 60, 4'b0111, 0));
        vecs.push_back(mk(5, 0, -1, 61, 4'b1111, 1));
        // lock loss in DONE
        vecs.push_back(mk(100, 0, -1,  99, 4'b1111, 1));
        vecs.push_back(mk(100, 0, -1, 100, 4'b0000, 0));
        vecs.push_back(mk(100, 0, -1, 107, 4'b0000, 0));
        vecs.push_back(mk(100, 0, -1, 108, 4'b0001, 0));
        // software reset in RELEASE
        vecs.push_back(mk(0, 30, 34, 29, 4'b0011, 0));
        vecs.push_back(mk(0, 30, 34, 30, 4'b0000, 0));
        vecs.push_back(mk(0, 30, 34, 41, 4'b0000, 0));
        vecs.push_back(mk(0, 30, 34, 42, 4'b0001, 0));
        vecs.push_back(mk(0, 30, 34, 58, 4'b0011, 0));
        // abort on an edge with a release due; sw_rst at the lock terminal count
        vecs.push_back(mk(24, 0, -1, 24, 4'b0000, 0));
        vecs.push_back(mk(56, 0, -1, 56, 4'b0000, 0));
        vecs.push_back(mk(0, 8, 8,  8, 4'b0000, 0));
        vecs.push_back(mk(0, 8, 8, 16, 4'b0001, 0));

        repeat (3) @(negedge clk);
        check("reset_state", {o_rst_n, o_done}, 5'b0);
        check("reset_state_min", {3'b0, m_rst_n, m_done}, 5'b0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // async reset mid-RELEASE, between edges 45 and 46
        i_rst_n = 1'b0;
        @(negedge clk);
        for (int e = 1; e <= 45; e++) begin
            i_lock = 1'b1; i_sw_rst = 1'b0; i_rst_n = 1'b1;
            @(negedge clk);
        end
        check("pre_async_edge45", {o_rst_n, o_done}, 5'b01110);
        #2 i_rst_n = 1'b0;
        #1 check("async_reset", {o_rst_n, o_done}, 5'b0);
        @(negedge clk);
        for (int e = 1; e <= 8; e++) begin
            i_rst_n = 1'b1;
            @(negedge clk);
            if (e == 7) check("after_async_edge7", {o_rst_n, o_done}, 5'b00000);
        end
        check("after_async_edge8", {o_rst_n, o_done}, 5'b00010);

        // minimal configuration
        i_rst_n = 1'b0;
        @(negedge clk);
        check("min_in_reset", {3'b0, m_rst_n, m_done}, 5'b0);
        i_lock = 1'b1; i_sw_rst = 1'b0; i_rst_n = 1'b1;
        @(negedge clk);
        check("min_edge1", {3'b0, m_rst_n, m_done}, 5'b00011);
        i_lock = 1'b0;
        @(negedge clk);
        check("min_lock_drop", {3'b0, m_rst_n, m_done}, 5'b0);
        i_lock = 1'b1;
        @(negedge clk);
        check("min_relock", {3'b0, m_rst_n, m_done}, 5'b00011);
        i_sw_rst = 1'b1;
        @(negedge clk);
        check("min_sw_rst", {3'b0, m_rst_n, m_done}, 5'b0);
        i_sw_rst = 1'b0;
        @(negedge clk);
        check("min_sw_release", {3'b0, m_rst_n, m_done}, 5'b00011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
